// File: rtl/fork_join_pkg.sv
// rtl/fork_join_pkg.sv - shared types and defaults for the fork/join dispatcher
package fork_join_pkg;

  localparam int N_CHILD   = 3;
  localparam int TIMEOUT_W = 16;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'd0,
    JOIN_ANY  = 2'd1,
    JOIN_NONE = 2'd2
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } fj_state_e;

  // The reserved encoding 3 behaves like JOIN_ALL.
  function automatic join_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return JOIN_ANY;
      2'd2:    return JOIN_NONE;
      default: return JOIN_ALL;
    endcase
  endfunction

endpackage

// File: rtl/fj_timeout_cnt.sv
// rtl/fj_timeout_cnt.sv - saturating elapsed-cycle counter with limit compare
module fj_timeout_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         hit_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (enable_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  // hit fires on the last permitted cycle so the caller can leave on that edge.
  assign hit_o   = (limit_i != '0) && (count_q == (limit_i - W'(1)));
  assign count_o = count_q;

endmodule

// File: rtl/fork_join_ctrl.sv
// rtl/fork_join_ctrl.sv - launches child workers and joins them under a selectable policy
module fork_join_ctrl #(
  parameter int N_CHILD   = fork_join_pkg::N_CHILD,
  parameter int TIMEOUT_W = fork_join_pkg::TIMEOUT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [N_CHILD-1:0]   child_mask,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic [N_CHILD-1:0]   child_start,
  input  logic [N_CHILD-1:0]   child_done,
  output logic                 busy,
  output logic                 parent_go,
  output logic                 all_done,
  output logic [N_CHILD-1:0]   done_vec,
  output logic                 timeout_err,
  output logic [TIMEOUT_W-1:0] elapsed
);

  import fork_join_pkg::*;

  fj_state_e            state_q;
  join_mode_e           mode_q;
  join_mode_e           start_mode;
  logic [N_CHILD-1:0]   mask_q;
  logic [TIMEOUT_W-1:0] limit_q;
  logic [N_CHILD-1:0]   pending_q;
  logic [N_CHILD-1:0]   done_vec_q;
  logic [N_CHILD-1:0]   child_start_q;
  logic                 go_sent_q;
  logic                 parent_go_q;
  logic                 all_done_q;
  logic                 busy_q;
  logic                 timeout_err_q;

  logic [N_CHILD-1:0]   done_hit;
  logic [N_CHILD-1:0]   pending_d;
  logic [N_CHILD-1:0]   done_vec_d;
  logic                 accept;
  logic                 cnt_hit;
  logic                 timeout_hit;
  logic                 wait_end;
  logic [TIMEOUT_W-1:0] elapsed_cnt;

  assign start_mode  = decode_mode(mode);
  assign accept      = (state_q == IDLE) && start;
  assign done_hit    = child_done & mask_q;
  assign pending_d   = pending_q & ~child_done;
  assign done_vec_d  = done_vec_q | done_hit;
  // Timeout is judged on the pending set before this cycle's dones, so a
  // last-moment done is still recorded yet the run still counts as timed out.
  assign timeout_hit = cnt_hit && (pending_q != '0);
  assign wait_end    = timeout_hit || (pending_d == '0);

  fj_timeout_cnt #(
    .W (TIMEOUT_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (accept),
    .enable_i (state_q == WAIT),
    .limit_i  (limit_q),
    .count_o  (elapsed_cnt),
    .hit_o    (cnt_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mode_q        <= JOIN_ALL;
      mask_q        <= '0;
      limit_q       <= '0;
      pending_q     <= '0;
      done_vec_q    <= '0;
      child_start_q <= '0;
      go_sent_q     <= 1'b0;
      parent_go_q   <= 1'b0;
      all_done_q    <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      child_start_q <= '0;
      parent_go_q   <= 1'b0;
      all_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q        <= start_mode;
            mask_q        <= child_mask;
            limit_q       <= timeout_cycles;
            pending_q     <= child_mask;
            done_vec_q    <= '0;
            timeout_err_q <= 1'b0;
            go_sent_q     <= 1'b0;
            busy_q        <= 1'b1;
            child_start_q <= child_mask;
            state_q       <= LAUNCH;
            // An empty launch completes immediately in every mode.
            if ((child_mask == '0) || (start_mode == JOIN_NONE)) begin
              parent_go_q <= 1'b1;
              go_sent_q   <= 1'b1;
            end
            if (child_mask == '0) begin
              all_done_q <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (mask_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          pending_q  <= pending_d;
          done_vec_q <= done_vec_d;
          if (!go_sent_q && (((mode_q == JOIN_ANY) && (done_hit != '0)) || wait_end)) begin
            parent_go_q <= 1'b1;
            go_sent_q   <= 1'b1;
          end
          if (wait_end) begin
            all_done_q <= 1'b1;
            state_q    <= FINISH;
            if (timeout_hit) begin
              timeout_err_q <= 1'b1;
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign child_start = child_start_q;
  assign busy        = busy_q;
  assign parent_go   = parent_go_q;
  assign all_done    = all_done_q;
  assign done_vec    = done_vec_q;
  assign timeout_err = timeout_err_q;
  assign elapsed     = elapsed_cnt;

endmodule

// File: tb/tb_fork_join_ctrl.sv
// tb/tb_fork_join_ctrl.sv - scoreboard bench for fork_join_ctrl with a run-level reference model
module tb_fork_join_ctrl;

  localparam int N   = 3;
  localparam int W   = 16;
  localparam int INF = 1000;
  localparam int K_START = 0;
  localparam int K_GO    = 1;
  localparam int K_DONE  = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   mode;
  logic [N-1:0] child_mask;
  logic [W-1:0] timeout_cycles;
  logic [N-1:0] child_start;
  logic [N-1:0] child_done;
  logic         busy;
  logic         parent_go;
  logic         all_done;
  logic [N-1:0] done_vec;
  logic         timeout_err;
  logic [W-1:0] elapsed;

  fork_join_ctrl #(.N_CHILD(N), .TIMEOUT_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .child_mask     (child_mask),
    .timeout_cycles (timeout_cycles),
    .child_start    (child_start),
    .child_done     (child_done),
    .busy           (busy),
    .parent_go      (parent_go),
    .all_done       (all_done),
    .done_vec       (done_vec),
    .timeout_err    (timeout_err),
    .elapsed        (elapsed)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           kind;
    int           cyc;
    logic [N-1:0] vec;
    logic         tout;
    int           el;
  } ev_t;

  ev_t expq[$];
  int  vectors     = 0;
  int  miscompares = 0;

  function automatic string kname(input int k);
    case (k)
      K_START: return "child_start";
      K_GO:    return "parent_go";
      default: return "all_done";
    endcase
  endfunction

  task automatic push_ev(input int kind, input int c, input logic [N-1:0] v, input logic t, input int el);
    ev_t e;
    e.kind = kind; e.cyc = c; e.vec = v; e.tout = t; e.el = el;
    expq.push_back(e);
  endtask

  task automatic check_event(input int kind);
    ev_t e;
    bit  ok;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL %s unexpected pulse at cycle %0d (no event expected)", kname(kind), cyc);
      return;
    end
    e  = expq.pop_front();
    ok = (e.kind == kind) && (e.cyc == cyc) && busy;
    case (kind)
      K_START: ok &= (child_start == e.vec) && (done_vec == '0) && !timeout_err;
      K_DONE:  ok &= (done_vec == e.vec) && (timeout_err == e.tout) && (int'(elapsed) == e.el);
      default: ;
    endcase
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got cyc=%0d busy=%b child_start=%b done_vec=%b tout=%b elapsed=%0d, want %s cyc=%0d vec=%b tout=%b elapsed=%0d",
               kname(kind), cyc, busy, child_start, done_vec, timeout_err, elapsed,
               kname(e.kind), e.cyc, e.vec, e.tout, e.el);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (child_start != '0) check_event(K_START);
      if (parent_go)         check_event(K_GO);
      if (all_done)          check_event(K_DONE);
    end
  end

  // One complete run: predict its events, then drive the children.
  // Returns at the negedge of the run's final busy cycle.
  task automatic run(input int md, input logic [N-1:0] mk, input int tl,
                     input int f0, input int f1, input int f2,
                     input int u0, input int u1, input int u2, input bit in_finish);
    int first [N];
    int dup   [N];
    int L, C, kend, fmin, go_c, E, eff;
    bit to;
    logic [N-1:0] dv, pv;
    first[0] = f0; first[1] = f1; first[2] = f2;
    dup[0]   = u0; dup[1]   = u1; dup[2]   = u2;
    mode = md[1:0]; child_mask = mk; timeout_cycles = W'(tl); start = 1'b1; child_done = '0;
    if (in_finish) @(negedge clk);
    L = cyc + 1;

    eff = (md == 3) ? 0 : md;
    C = 0; fmin = INF;
    for (int i = 0; i < N; i++) begin
      if (mk[i]) begin
        C = (first[i] == 0) ? INF : ((first[i] > C) ? first[i] : C);
        if (first[i] != 0 && first[i] < fmin) fmin = first[i];
      end
    end
    if (mk == '0) begin
      kend = 0; to = 0; E = L; go_c = L; dv = '0;
      push_ev(K_GO, L, '0, 1'b0, 0);
      push_ev(K_DONE, L, '0, 1'b0, 0);
    end else begin
      if (tl != 0 && C >= tl) begin kend = tl; to = 1; end
      else begin kend = C; to = 0; end
      dv = '0;
      for (int i = 0; i < N; i++)
        if (mk[i] && first[i] != 0 && first[i] <= kend) dv[i] = 1'b1;
      E = L + kend + 1;
      if (eff == 2)      go_c = L;
      else if (eff == 1) go_c = L + ((fmin < kend) ? fmin : kend) + 1;
      else               go_c = E;
      push_ev(K_START, L, mk, 1'b0, 0);
      push_ev(K_GO, go_c, '0, 1'b0, 0);
      push_ev(K_DONE, E, dv, to, kend);
    end

    @(negedge clk);
    start = 1'b0; mode = 2'($urandom); child_mask = N'($urandom);
    timeout_cycles = W'($urandom); child_done = N'($urandom);
    if (mk != '0) begin
      for (int k = 1; k <= kend; k++) begin
        @(negedge clk);
        pv = '0;
        for (int i = 0; i < N; i++)
          if (first[i] == k || (first[i] != 0 && dup[i] != 0 && first[i] + dup[i] == k)) pv[i] = 1'b1;
        child_done = pv;
        start = ($urandom_range(3) == 0);
        child_mask = N'($urandom);
        mode = 2'($urandom);
      end
      @(negedge clk);
    end
    child_done = '0; start = 1'b0;
  endtask

  initial begin : main
    int md, tl, f [N], u [N];
    logic [N-1:0] mk;
    bit b2b, ok;
    rst = 1'b1; start = 1'b0; mode = '0; child_mask = '0; timeout_cycles = '0; child_done = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy || child_start != '0 || parent_go || all_done || done_vec != '0 || timeout_err || elapsed != '0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b cs=%b go=%b ad=%b dv=%b te=%b el=%0d, want all 0",
               busy, child_start, parent_go, all_done, done_vec, timeout_err, elapsed);
    end
    rst = 1'b0;
    @(negedge clk);

    run(0, 3'b111, 0, 3, 5, 8, 0, 0, 0, 0);   @(negedge clk);
    run(1, 3'b111, 0, 9, 4, 4, 0, 2, 0, 0);   @(negedge clk);
    run(2, 3'b101, 0, 3, 2, 6, 0, 0, 0, 0);   @(negedge clk);
    run(0, 3'b011, 10, 4, 0, 0, 0, 0, 0, 0);
    run(1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 1);
    run(3, 3'b111, 0, 1, 1, 1, 2, 0, 3, 1);
    run(1, 3'b110, 1, 0, 1, 0, 0, 0, 0, 1);   @(negedge clk);

    b2b = 0;
    for (int r = 0; r < 30; r++) begin
      md = $urandom_range(3);
      mk = N'($urandom_range(7));
      tl = ($urandom_range(1) == 0) ? 0 : $urandom_range(1, 14);
      for (int i = 0; i < N; i++) begin
        f[i] = (tl != 0 && $urandom_range(3) == 0) ? 0 : $urandom_range(1, 12);
        u[i] = ($urandom_range(1) == 0) ? $urandom_range(1, 4) : 0;
      end
      run(md, mk, tl, f[0], f[1], f[2], u[0], u[1], u[2], b2b);
      b2b = $urandom_range(1);
      if (!b2b) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    if (b2b) @(negedge clk);

    // Mid-run reset: outputs must drop without waiting for a clock edge.
    mode = 2'd0; child_mask = 3'b111; timeout_cycles = '0; start = 1'b1;
    push_ev(K_START, cyc + 1, 3'b111, 1'b0, 0);
    @(negedge clk); start = 1'b0;
    @(negedge clk); child_done = 3'b001;
    @(negedge clk); child_done = '0;
    vectors++;
    if (!busy || done_vec != 3'b001 || elapsed != W'(1)) begin
      miscompares++;
      $display("FAIL pre_reset_wait: busy=%b dv=%b el=%0d, want busy=1 dv=001 el=1", busy, done_vec, elapsed);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy || child_start != '0 || parent_go || all_done || done_vec != '0 || timeout_err || elapsed != '0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b cs=%b go=%b ad=%b dv=%b te=%b el=%0d, want all 0",
               busy, child_start, parent_go, all_done, done_vec, timeout_err, elapsed);
    end
    @(negedge clk); rst = 1'b0; child_done = 3'b111;
    @(negedge clk); child_done = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy || done_vec != '0) begin
      miscompares++;
      $display("FAIL stale_done: busy=%b dv=%b, want busy=0 dv=000", busy, done_vec);
    end
    run(0, 3'b110, 0, 0, 2, 3, 0, 0, 0, 0);
    repeat (4) @(negedge clk);

    vectors++;
    ok = (expq.size() == 0);
    if (!ok) begin
      miscompares++;
      $display("FAIL missing_events: %0d expected events never seen, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
